// File: rtl/compound_req_accumulator.sv
// Request types, a small generic response FIFO, and the compound request
// accumulator that consumes write/read requests and queues read responses.
package scam_model_types;
  typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_e;

  typedef struct packed {
    mode_e              mode;
    logic signed [31:0] x;
    logic               y;
  } CompoundType;

  typedef struct packed {
    logic signed [31:0] x;
    logic [31:0]        y;
  } record_t;
endpackage

// Generic circular FIFO with a registered valid flag and zeroed output when empty.
// Latency: a push is visible at the head one cycle later; there is no same-cycle bypass.
// Backpressure: o_full refuses pushes unless a pop happens in the same cycle.
module crq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_pop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_vld;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;

  assign w_pop  = r_vld & i_pop_rdy;
  assign o_full = (r_count == (AW+1)'(DEPTH));
  // A pop frees the slot the push lands in, so full+pop still accepts a push.
  assign w_push = i_push & (~o_full | w_pop);
  assign o_pop  = w_pop;
  assign o_vld  = r_vld;
  assign o_dat  = r_vld ? r_mem[r_rd_ptr] : '0;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_vld    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_vld   <= (w_count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

// Accumulator: writes load/add into acc, reads queue {x, acc} responses.
// Latency: acc and responses update one cycle after acceptance.
// Backpressure: reads stall while the FIFO is full with no pop; writes never stall.
module compound_req_accumulator
  import scam_model_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  CompoundType        req_in_sig,
  input  logic               req_in_sync,
  output logic               req_in_notify,
  output record_t            rsp_out_sig,
  output logic               rsp_out_notify,
  input  logic               rsp_out_sync,
  output logic signed [31:0] acc_out
);
  logic signed [31:0]     r_acc;
  logic                   w_is_write;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_push;
  record_t                w_push_dat;
  logic [$bits(record_t)-1:0] w_rsp_dat;

  assign w_is_write    = (req_in_sig.mode == MODE_WRITE);
  assign req_in_notify = ~rst & (w_is_write | ~w_full | w_pop);
  assign w_accept      = req_in_sync & req_in_notify;
  assign w_push        = w_accept & ~w_is_write;

  // Response carries the accumulator value from before this edge.
  assign w_push_dat.x = req_in_sig.x;
  assign w_push_dat.y = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept && w_is_write) begin
      r_acc <= req_in_sig.y ? (r_acc + req_in_sig.x) : req_in_sig.x;
    end
  end

  crq_fifo #(
    .W     ($bits(record_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop_rdy  (rsp_out_sync),
    .o_vld      (rsp_out_notify),
    .o_dat      (w_rsp_dat),
    .o_full     (w_full),
    .o_pop      (w_pop)
  );

  assign rsp_out_sig = w_rsp_dat;
  assign acc_out     = r_acc;
endmodule

// File: doc/compound_req_accumulator.md
Name: compound_req_accumulator

Overview:
- Downstream consumer of CompoundType request transactions (mode/x/y) from the scam_model_types package.
- Write requests update an internal 32-bit signed accumulator.
- Read requests produce a record_t response {x, y}, queued in a small output FIFO for the next stage.
- Sits between the CompoundType producer and any record_t consumer. Uses blocking-port handshakes on both sides.

Parameters:
- DEPTH, 4, number of record_t entries in the output FIFO. Power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in_sig  input  CompoundType  incoming request {mode, x (integer), y (bit)}.
- req_in_sync  input  1  producer has a valid request on req_in_sig.
- req_in_notify  output  1  block accepts the request this cycle.
- rsp_out_sig  output  record_t  head-of-FIFO response {x (integer), y (bit[31:0])}.
- rsp_out_notify  output  1  rsp_out_sig is valid.
- rsp_out_sync  input  1  consumer takes the response this cycle.
- acc_out  output  32  current accumulator value (signed integer). Observation port.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - acc=0; FIFO empty (read pointer, write pointer and count = 0).
  - req_in_notify=0, rsp_out_notify=0, rsp_out_sig={0,0}, acc_out=0.
  - Reset mid-operation drops all queued responses and any in-flight request. There is no partial state.
- Request acceptance: a request is accepted in a cycle where req_in_sync=1 and req_in_notify=1.
  - req_in_notify is combinational: asserted when not in reset and (FIFO not full, or a pop happens this cycle).
  - Write-mode requests are always acceptable, even when the FIFO is full.
- Write request (mode=write), effect visible on acc/acc_out the next cycle:
  - y=1: acc <= acc + x. 32-bit two's-complement wrap, no saturation, no overflow flag.
  - y=0: acc <= x (load).
- Read request (mode=read): push record_t {x: req.x, y: acc value before this edge} into the FIFO.
  - Latency: response visible at the FIFO head the next cycle if the FIFO was empty.
- Ordering: one request per cycle. A read issued the cycle after a write sees the updated acc.
- FIFO:
  - Circular buffer with pointers wrapping modulo DEPTH.
  - rsp_out_notify = (count != 0), registered.
  - rsp_out_sig = entry at the read pointer.
  - Pop when rsp_out_notify && rsp_out_sync. rsp_out_sync while empty is ignored.
- Boundary conditions:
  - Full and read request pending: req_in_notify=0, the request stalls, acc is unchanged.
  - Full with a pop and a read push in the same cycle: both happen; count stays at DEPTH.
  - Empty with a push: count becomes 1. No same-cycle bypass to the output.
  - Simultaneous push and pop at any non-full count: count is unchanged and the pointers both advance.
- No internal FSM beyond the two-state (empty / non-empty) response-valid logic and the counter. acc_out mirrors the acc register.

Test Plan:
- Reset and load:
  - Stimulus: assert rst for 2 cycles. Check all outputs are 0. Then send write{x=10,y=0}, then read{x=7}.
  - Expected: acc_out=10 one cycle after the write. Response {x=7, y=10} appears with rsp_out_notify=1.
- Accumulate and wrap:
  - Stimulus: write{x=0x7FFFFFFF,y=0}, then write{x=1,y=1}, then read{x=1}.
  - Expected: acc_out=0x80000000. Response y=0x80000000.
- Full backpressure (DEPTH=4):
  - Stimulus: hold rsp_out_sync=0 and issue 5 reads.
  - Expected: first 4 accepted. 5th sees req_in_notify=0 and stalls. A write issued while full is accepted.
  - Release rsp_out_sync=1: responses drain in order and the 5th read is then accepted.
- Simultaneous push and pop at full:
  - Stimulus: FIFO full; rsp_out_sync=1 and a read request in the same cycle.
  - Expected: both complete, count stays 4, order preserved over 8 drained responses.
- Reset mid-stream:
  - Stimulus: 3 responses queued and acc=55; assert rst for 1 cycle.
  - Expected: rsp_out_notify=0 and acc_out=0 the next cycle. A subsequent read returns y=0.
- Empty pop:
  - Stimulus: rsp_out_sync=1 with the FIFO empty.
  - Expected: no pointer change. The next read response is still correct.
